// File: rtl/gpio_in_debounce.sv
// Board input conditioner: per-bit synchronizer, independent debounce counters,
// clean levels plus registered single-cycle rise/fall/changed strobes.
module gpio_in_debounce #(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  assign sync = sync_q[SYNC_STAGES-1];

  // A counter only advances while the synchronized level disagrees with the
  // accepted level; any agreement clears it, so glitches never accumulate.
  always_comb begin
    stable_d = sw_stable;
    rise_d   = '0;
    fall_d   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync[i] == sw_stable[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync[i];
        cnt_d[i]    = '0;
        rise_d[i]   = sync[i];
        fall_d[i]   = ~sync[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      sw_stable <= '0;
      sw_rise   <= '0;
      sw_fall   <= '0;
      changed   <= 1'b0;
    end else begin
      sync_q[0] <= sw_raw;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sw_stable <= stable_d;
      sw_rise   <= rise_d;
      sw_fall   <= fall_d;
      changed   <= |{rise_d, fall_d};
    end
  end

endmodule
